// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcode map, jump-select encoding and
// the fetch/decode sequencer state encoding.
package cpu_pkg;

  localparam int OPC_W  = 4;
  localparam int JSEL_W = 5;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_ALU_LO = 4'h1;
  localparam logic [OPC_W-1:0] OP_ALU_HI = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'h8;
  localparam logic [OPC_W-1:0] OP_JZ     = 4'h9;
  localparam logic [OPC_W-1:0] OP_JNZ    = 4'hA;
  localparam logic [OPC_W-1:0] OP_JC     = 4'hB;
  localparam logic [OPC_W-1:0] OP_JNC    = 4'hC;
  localparam logic [OPC_W-1:0] OP_RSV_D  = 4'hD;
  localparam logic [OPC_W-1:0] OP_RSV_E  = 4'hE;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

  // One-hot jump select, bit order matches the jump logic strobe inputs.
  localparam logic [JSEL_W-1:0] JS_NONE = 5'b00000;
  localparam logic [JSEL_W-1:0] JS_JMP  = 5'b00001;
  localparam logic [JSEL_W-1:0] JS_JZ   = 5'b00010;
  localparam logic [JSEL_W-1:0] JS_JNZ  = 5'b00100;
  localparam logic [JSEL_W-1:0] JS_JC   = 5'b01000;
  localparam logic [JSEL_W-1:0] JS_JNC  = 5'b10000;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode classifier: jump / halt / reserved detection and the
// one-hot jump select. Shared with the jump logic bench.
module opcode_classify
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_jump,
  output logic                is_halt,
  output logic                is_illegal,
  output logic [4:0]          jump_sel
);

  always_comb begin
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    jump_sel   = JS_NONE;
    case (opcode)
      OPCODE_W'(OP_JMP): begin
        is_jump  = 1'b1;
        jump_sel = JS_JMP;
      end
      OPCODE_W'(OP_JZ): begin
        is_jump  = 1'b1;
        jump_sel = JS_JZ;
      end
      OPCODE_W'(OP_JNZ): begin
        is_jump  = 1'b1;
        jump_sel = JS_JNZ;
      end
      OPCODE_W'(OP_JC): begin
        is_jump  = 1'b1;
        jump_sel = JS_JC;
      end
      OPCODE_W'(OP_JNC): begin
        is_jump  = 1'b1;
        jump_sel = JS_JNC;
      end
      OPCODE_W'(OP_RSV_D),
      OPCODE_W'(OP_RSV_E): is_illegal = 1'b1;
      OPCODE_W'(OP_HALT):  is_halt    = 1'b1;
      // NOP and ALU ops are single-byte and need no classification flags.
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_sequencer.sv
// Instruction fetch/decode sequencer: fetches opcode and operand bytes, steps
// FETCH/DECODE/OPERAND/EXECUTE and drives the jump logic strobes.
module decode_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OPCODE_W = 4
) (
  input  logic                clock,
  input  logic                input_clear_n,
  input  logic [DATA_W-1:0]   input_mem_data,
  input  logic                input_mem_ready,
  output logic                output_mem_read,
  output logic                output_load_ir,
  output logic                output_load_operand,
  output logic                output_increment,
  output logic                output_execute,
  output logic                output_jump,
  output logic                output_jumpz,
  output logic                output_jumpnz,
  output logic                output_jumpc,
  output logic                output_jumpnc,
  output logic [OPCODE_W-1:0] output_opcode,
  output logic                output_illegal,
  output logic                output_halted
);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic [OPCODE_W-1:0] opcode_q;

  logic                is_jump;
  logic                is_halt;
  logic                is_illegal;
  logic [4:0]          jump_sel;

  logic                mem_read_c;
  logic                load_ir_c;
  logic                load_operand_c;
  logic                increment_c;
  logic                execute_c;
  logic                illegal_c;
  logic                halted_c;
  logic [4:0]          jump_c;

  // Operand bits are consumed by the external operand register, not here.
  logic                unused_operand_bits;
  assign unused_operand_bits = ^input_mem_data[DATA_W-OPCODE_W-1:0];

  opcode_classify #(
    .OPCODE_W (OPCODE_W)
  ) u_classify (
    .opcode     (opcode_q),
    .is_jump    (is_jump),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .jump_sel   (jump_sel)
  );

  always_ff @(posedge clock or negedge input_clear_n) begin
    if (!input_clear_n) begin
      state    <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_ir_c) begin
        opcode_q <= input_mem_data[DATA_W-1 -: OPCODE_W];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    mem_read_c     = 1'b0;
    load_ir_c      = 1'b0;
    load_operand_c = 1'b0;
    increment_c    = 1'b0;
    execute_c      = 1'b0;
    illegal_c      = 1'b0;
    halted_c       = 1'b0;
    jump_c         = JS_NONE;
    case (state)
      ST_FETCH: begin
        mem_read_c = 1'b1;
        if (input_mem_ready) begin
          load_ir_c   = 1'b1;
          increment_c = 1'b1;
          state_nxt   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Reserved opcodes retire as a NOP without an execute phase.
        if (is_illegal) begin
          illegal_c = 1'b1;
          state_nxt = ST_FETCH;
        end else if (is_halt) begin
          state_nxt = ST_HALT;
        end else if (is_jump) begin
          state_nxt = ST_OPERAND;
        end else begin
          state_nxt = ST_EXECUTE;
        end
      end
      ST_OPERAND: begin
        mem_read_c = 1'b1;
        if (input_mem_ready) begin
          load_operand_c = 1'b1;
          increment_c    = 1'b1;
          state_nxt      = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        execute_c = 1'b1;
        jump_c    = is_jump ? jump_sel : JS_NONE;
        state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  // Outputs are qualified by the reset so every strobe drops the moment reset asserts.
  assign output_mem_read     = mem_read_c     & input_clear_n;
  assign output_load_ir      = load_ir_c      & input_clear_n;
  assign output_load_operand = load_operand_c & input_clear_n;
  assign output_increment    = increment_c    & input_clear_n;
  assign output_execute      = execute_c      & input_clear_n;
  assign output_illegal      = illegal_c      & input_clear_n;
  assign output_halted       = halted_c       & input_clear_n;
  assign output_jump         = jump_c[0]      & input_clear_n;
  assign output_jumpz        = jump_c[1]      & input_clear_n;
  assign output_jumpnz       = jump_c[2]      & input_clear_n;
  assign output_jumpc        = jump_c[3]      & input_clear_n;
  assign output_jumpnc       = jump_c[4]      & input_clear_n;
  assign output_opcode       = opcode_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: directed instruction bytes push
// expected strobe events; a negedge monitor pops and compares them.
module tb_decode_sequencer;

  localparam int DATA_W   = 8;
  localparam int OPCODE_W = 4;

  localparam logic [11:0] B_RD  = 12'h800;
  localparam logic [11:0] B_IR  = 12'h400;
  localparam logic [11:0] B_OPD = 12'h200;
  localparam logic [11:0] B_INC = 12'h100;
  localparam logic [11:0] B_EX  = 12'h080;
  localparam logic [11:0] B_JMP = 12'h040;
  localparam logic [11:0] B_JZ  = 12'h020;
  localparam logic [11:0] B_JNZ = 12'h010;
  localparam logic [11:0] B_JC  = 12'h008;
  localparam logic [11:0] B_JNC = 12'h004;
  localparam logic [11:0] B_ILL = 12'h002;
  localparam logic [11:0] B_HLT = 12'h001;

  logic                clock = 1'b0;
  logic                input_clear_n = 1'b0;
  logic [DATA_W-1:0]   input_mem_data = '0;
  logic                input_mem_ready = 1'b0;
  logic                output_mem_read;
  logic                output_load_ir;
  logic                output_load_operand;
  logic                output_increment;
  logic                output_execute;
  logic                output_jump;
  logic                output_jumpz;
  logic                output_jumpnz;
  logic                output_jumpc;
  logic                output_jumpnc;
  logic [OPCODE_W-1:0] output_opcode;
  logic                output_illegal;
  logic                output_halted;

  decode_sequencer #(
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W)
  ) dut (
    .clock               (clock),
    .input_clear_n       (input_clear_n),
    .input_mem_data      (input_mem_data),
    .input_mem_ready     (input_mem_ready),
    .output_mem_read     (output_mem_read),
    .output_load_ir      (output_load_ir),
    .output_load_operand (output_load_operand),
    .output_increment    (output_increment),
    .output_execute      (output_execute),
    .output_jump         (output_jump),
    .output_jumpz        (output_jumpz),
    .output_jumpnz       (output_jumpnz),
    .output_jumpc        (output_jumpc),
    .output_jumpnc       (output_jumpnc),
    .output_opcode       (output_opcode),
    .output_illegal      (output_illegal),
    .output_halted       (output_halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [11:0] vec;
    logic [3:0]  op;
    string       name;
  } exp_t;

  typedef struct {
    logic [7:0]  ib;
    logic [7:0]  ob;
    int          kind;
    int          stall;
    logic [11:0] ev;
    string       name;
  } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tbl[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          inc_seen = 0;
  logic [3:0]  last_op = 4'h0;
  logic [11:0] obs;

  assign obs = {output_mem_read, output_load_ir, output_load_operand, output_increment,
                output_execute, output_jump, output_jumpz, output_jumpnz, output_jumpc,
                output_jumpnc, output_illegal, output_halted};

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: any strobe or halted in a cycle is one observed event.
  always @(negedge clock) begin
    if (input_clear_n === 1'b1 && (obs & ~B_RD) != 12'h000) begin
      checks++;
      if (output_increment === 1'b1) inc_seen++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got=%03h required=none", cyc, obs);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.vec !== obs || mon_e.op !== output_opcode) begin
          errors++;
          $display("FAIL %s got cyc=%0d vec=%03h op=%h required cyc=%0d vec=%03h op=%h",
                   mon_e.name, cyc, obs, output_opcode, mon_e.cyc, mon_e.vec, mon_e.op);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int c, input logic [11:0] v, input logic [3:0] op, input string n);
    exp_t e;
    e.cyc  = c;
    e.vec  = v;
    e.op   = op;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", n, got, req);
    end
  endtask

  task automatic idle(input int n);
    input_mem_ready = 1'b0;
    input_mem_data  = 8'h00;
    repeat (n) step();
  endtask

  task automatic do_fetch(input logic [7:0] ib, input string n);
    input_mem_ready = 1'b1;
    input_mem_data  = ib;
    push(cyc, B_RD | B_IR | B_INC, last_op, n);
    last_op = ib[7:4];
    step();
  endtask

  // kind: 0 single-byte, 1 jump, 2 reserved. Ready stays high outside stalls.
  task automatic run_op(input vec_t t);
    int k;
    k = cyc;
    do_fetch(t.ib, {t.name, "_fetch"});
    input_mem_data = 8'hFF;
    if (t.kind == 2) begin
      push(k + 1, t.ev, t.ib[7:4], {t.name, "_illegal"});
      step();
    end else if (t.kind == 1) begin
      step();
      input_mem_ready = 1'b0;
      repeat (t.stall) step();
      input_mem_ready = 1'b1;
      input_mem_data  = t.ob;
      push(k + 2 + t.stall, B_RD | B_OPD | B_INC, t.ib[7:4], {t.name, "_operand"});
      step();
      input_mem_data = 8'hFF;
      push(k + 3 + t.stall, t.ev, t.ib[7:4], {t.name, "_exec"});
      step();
    end else begin
      step();
      push(k + 2, t.ev, t.ib[7:4], {t.name, "_exec"});
      step();
    end
  endtask

  initial begin
    int k;
    tbl.push_back('{8'h35, 8'h00, 0, 0, B_EX,         "alu35"});
    tbl.push_back('{8'h90, 8'h42, 1, 0, B_EX | B_JZ,  "jz90"});
    tbl.push_back('{8'hC0, 8'h11, 1, 3, B_EX | B_JNC, "jncC0"});
    tbl.push_back('{8'hD0, 8'h00, 2, 0, B_ILL,        "rsvD0"});
    tbl.push_back('{8'h07, 8'h00, 0, 0, B_EX,         "nop07"});
    tbl.push_back('{8'h7F, 8'h00, 0, 0, B_EX,         "alu7F"});
    tbl.push_back('{8'h80, 8'h20, 1, 0, B_EX | B_JMP, "jmp80"});
    tbl.push_back('{8'hB0, 8'h33, 1, 1, B_EX | B_JC,  "jcB0"});
    tbl.push_back('{8'hE0, 8'h00, 2, 0, B_ILL,        "rsvE0"});

    // Power-on reset.
    #2;
    chk("por_strobes", 32'(obs & ~B_RD), 32'd0);
    chk("por_opcode", 32'(output_opcode), 32'd0);
    step();
    step();
    input_clear_n = 1'b1;
    #1;
    chk("por_rel_mem_read", 32'(output_mem_read), 32'd1);
    idle(2);

    // Reset while waiting in OPERAND with ready low.
    do_fetch(8'h90, "rstopd_fetch");
    input_mem_ready = 1'b0;
    step();
    step();
    chk("opd_wait_mem_read", 32'(output_mem_read), 32'd1);
    chk("opd_wait_opcode", 32'(output_opcode), 32'h9);
    input_clear_n = 1'b0;
    #1;
    chk("rstopd_strobes", 32'(obs & ~B_RD), 32'd0);
    chk("rstopd_opcode", 32'(output_opcode), 32'd0);
    step();
    step();
    input_clear_n = 1'b1;
    last_op = 4'h0;
    #1;
    chk("rstopd_rel_mem_read", 32'(output_mem_read), 32'd1);
    chk("rstopd_rel_opcode", 32'(output_opcode), 32'd0);
    idle(4);

    // Directed instruction stream, mostly back to back.
    for (int i = 0; i < tbl.size(); i++) begin
      if (i == 4) idle(2);
      run_op(tbl[i]);
    end

    // Reset landing in the EXECUTE cycle of a JNZ.
    k = cyc;
    do_fetch(8'hA0, "rstex_fetch");
    input_mem_data = 8'hFF;
    step();
    input_mem_data = 8'h5A;
    push(k + 2, B_RD | B_OPD | B_INC, 4'hA, "rstex_operand");
    step();
    chk("rstex_execute", 32'(output_execute), 32'd1);
    chk("rstex_jumpnz", 32'(output_jumpnz), 32'd1);
    input_clear_n = 1'b0;
    #1;
    chk("rstex_strobes", 32'(obs & ~B_RD), 32'd0);
    chk("rstex_opcode", 32'(output_opcode), 32'd0);
    step();
    input_clear_n   = 1'b1;
    input_mem_ready = 1'b0;
    last_op         = 4'h0;
    #1;
    chk("rstex_rel_mem_read", 32'(output_mem_read), 32'd1);
    idle(4);

    // HALT holds for 20 cycles with ready high until reset.
    k = cyc;
    do_fetch(8'hF0, "halt_fetch");
    input_mem_data = 8'hFF;
    step();
    for (int i = 0; i < 20; i++) begin
      push(k + 2 + i, B_HLT, 4'hF, "halt_hold");
      input_mem_data = 8'h35 + i[7:0];
      step();
    end
    input_clear_n = 1'b0;
    #1;
    chk("halt_rst_halted", 32'(output_halted), 32'd0);
    chk("halt_rst_opcode", 32'(output_opcode), 32'd0);
    step();
    input_mem_ready = 1'b0;
    input_clear_n   = 1'b1;
    #1;
    chk("halt_rel_mem_read", 32'(output_mem_read), 32'd1);
    chk("halt_rel_halted", 32'(output_halted), 32'd0);
    idle(3);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("increment_count", 32'(inc_seen), 32'd17);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
